// File: rtl/uart_rx_ctrl.sv
// UART receive-path controller: baud-generator enable/divisor, frame tracking and a 4-entry show-ahead byte FIFO.
// Optional idle-timeout flag is built when UART_RX_CTRL_TIMEOUT_EN is defined.
module uart_rx_ctrl #(
   parameter int BITWIDTH     = 8,
   parameter int DIV_W        = 8,
   parameter int RESET_DIV    = 196,
   parameter int OSR          = 16,
   parameter int TIMEOUT_BITS = 4
) (
   input  logic                clk,
   input  logic                reset_n,
   input  logic                rx,
   input  logic                s_tick,
   input  logic                rx_done_tick,
   input  logic [BITWIDTH-1:0] rx_dout,
   output logic                bgen_enable,
   output logic [DIV_W-1:0]    bgen_final_value,
   input  logic                cfg_en,
   input  logic                cfg_wr,
   input  logic [DIV_W-1:0]    cfg_div,
   output logic                cfg_pending,
   output logic                busy,
   input  logic                flush,
   output logic                m_valid,
   output logic [BITWIDTH-1:0] m_data,
   input  logic                m_ready,
   output logic [2:0]          fifo_count,
   output logic                overrun,
   input  logic                ovr_clr,
   output logic                timeout_irq
);

   typedef enum logic [1:0] {S_OFF, S_IDLE, S_BUSY} state_t;

   state_t state, state_nx;

   logic [DIV_W-1:0]    pend_div;
   logic [BITWIDTH-1:0] mem [4];
   logic [1:0]          wptr, rptr, rptr_nx;
   logic [2:0]          count;
   logic [BITWIDTH-1:0] head_nx;
   logic                push_req, push_do, pop, full, ovr_ev;

   always_ff @(posedge clk) begin
      if (!reset_n) state <= S_OFF;
      else          state <= state_nx;
   end

   always_comb begin
      state_nx = state;
      unique case (state)
         S_OFF:   if (cfg_en)       state_nx = S_IDLE;
         S_IDLE:  if (!rx)          state_nx = S_BUSY;
         S_BUSY:  if (rx_done_tick) state_nx = S_IDLE;
         default:                   state_nx = S_OFF;
      endcase
      if (!cfg_en) state_nx = S_OFF;
   end

   assign bgen_enable = (state != S_OFF);
   assign busy        = (state == S_BUSY);

   // The divisor only moves when no frame is being sampled with it.
   always_ff @(posedge clk) begin
      if (!reset_n) begin
         bgen_final_value <= DIV_W'(RESET_DIV);
         pend_div         <= DIV_W'(RESET_DIV);
         cfg_pending      <= 1'b0;
      end else if (cfg_wr) begin
         pend_div    <= cfg_div;
         cfg_pending <= 1'b1;
      end else if (cfg_pending && state != S_BUSY) begin
         bgen_final_value <= pend_div;
         cfg_pending      <= 1'b0;
      end
   end

   assign full     = (count == 3'd4);
   assign m_valid  = (count != 3'd0);
   assign pop      = m_valid && m_ready;
   assign push_req = rx_done_tick && (state != S_OFF);
   assign push_do  = push_req && (!full || pop) && !flush;
   assign ovr_ev   = push_req && full && !pop && !flush;
   assign rptr_nx  = rptr + 2'(pop);
   // Head after this edge: bypass the incoming byte when it lands in the slot being exposed.
   assign head_nx  = (push_do && wptr == rptr_nx) ? rx_dout : mem[rptr_nx];

   always_ff @(posedge clk) begin
      if (push_do) mem[wptr] <= rx_dout;
   end

   always_ff @(posedge clk) begin
      if (!reset_n) begin
         wptr    <= 2'd0;
         rptr    <= 2'd0;
         count   <= 3'd0;
         m_data  <= '0;
         overrun <= 1'b0;
      end else begin
         if (flush) begin
            wptr  <= 2'd0;
            rptr  <= 2'd0;
            count <= 3'd0;
         end else begin
            if (push_do) wptr <= wptr + 2'd1;
            rptr   <= rptr_nx;
            count  <= count + 3'(push_do) - 3'(pop);
            m_data <= head_nx;
         end
         if (ovr_ev)       overrun <= 1'b1;
         else if (ovr_clr) overrun <= 1'b0;
      end
   end

   assign fifo_count = count;

`ifdef UART_RX_CTRL_TIMEOUT_EN
   localparam int TERM = TIMEOUT_BITS * OSR;
   localparam int TO_W = $clog2(TERM + 1);

   logic [TO_W-1:0] to_cnt;
   logic            to_flag, to_inc;

   assign to_inc = s_tick && (state == S_IDLE) && m_valid && (to_cnt != TO_W'(TERM));

   // Any FIFO activity restarts the idle measurement and withdraws the flag.
   always_ff @(posedge clk) begin
      if (!reset_n) begin
         to_cnt  <= '0;
         to_flag <= 1'b0;
      end else if (push_req || pop || flush) begin
         to_cnt  <= '0;
         to_flag <= 1'b0;
      end else if (to_inc) begin
         to_cnt <= to_cnt + TO_W'(1);
         if (to_cnt == TO_W'(TERM - 1)) to_flag <= 1'b1;
      end
   end

   assign timeout_irq = to_flag;
`else
   logic unused_tick;
   assign unused_tick = s_tick | (OSR == 0) | (TIMEOUT_BITS == 0);
   assign timeout_irq = 1'b0;
`endif

endmodule

// File: doc/uart_rx_ctrl.md
# uart_rx_ctrl

Receive-side controller that sequences the UART receive path: it owns the baud-generator configuration (enable and divisor), tracks whether a frame is in flight, and captures each byte completed by the receiver into a 4-entry show-ahead FIFO. The host drains the FIFO through a valid/ready port. The block sits between the baud generator, the UART receiver and the host/bus logic. It replaces the ad-hoc write/read strobing of the receive buffer.

## Interface
- BITWIDTH, 8, data byte width
- DIV_W, 8, baud divisor width (matches the baud generator's FINAL_VALUE)
- RESET_DIV, 196, divisor loaded at reset
- OSR, 16, s_tick pulses per bit time
- TIMEOUT_BITS, 4, idle bit times before the timeout flag asserts
- clk  in  1  single clock; all logic on rising edge
- reset_n  in  1  synchronous, active-low reset
- rx  in  1  serial line, already synchronised; used only for start detection
- s_tick  in  1  oversample tick from the baud generator
- rx_done_tick  in  1  one-cycle pulse from the receiver; byte valid on rx_dout
- rx_dout  in  BITWIDTH  received byte
- bgen_enable  out  1  baud generator enable
- bgen_final_value  out  DIV_W  baud generator divisor
- cfg_en  in  1  receive enable
- cfg_wr  in  1  one-cycle divisor write strobe
- cfg_div  in  DIV_W  new divisor, sampled when cfg_wr=1
- cfg_pending  out  1  divisor write accepted but not yet applied
- busy  out  1  frame in flight
- flush  in  1  empties the FIFO
- m_valid  out  1  FIFO head valid
- m_data  out  BITWIDTH  FIFO head byte (registered)
- m_ready  in  1  host pop; transfers when m_valid & m_ready
- fifo_count  out  3  occupancy, 0..4
- overrun  out  1  sticky: a byte was dropped
- ovr_clr  in  1  clears overrun
- timeout_irq  out  1  idle timeout flag

## Operation
- FSM states: OFF, IDLE, BUSY.
- OFF: bgen_enable=0. Moves to IDLE when cfg_en=1.
- IDLE: bgen_enable=1. Moves to BUSY on rx=0 (start edge).
- BUSY: moves to IDLE on rx_done_tick.
- cfg_en=0 in any state forces OFF on the next edge. An in-flight frame is abandoned. rx_done_tick is ignored while in OFF.
- busy=1 only in BUSY.
- Divisor update:
  - cfg_wr latches cfg_div into a pending register and sets cfg_pending.
  - The pending value is applied to bgen_final_value on the first edge where the state is OFF or IDLE, then cfg_pending clears.
  - A divisor is never changed while in BUSY.
  - A second cfg_wr before the apply overwrites the pending value (last write wins).
- FIFO: 4 entries, 2-bit write and read pointers that wrap modulo 4.
  - Push: rx_done_tick while in IDLE or BUSY.
  - Pop: m_valid & m_ready.
- Boundary rules:
  - Full, push and no pop: byte dropped, overrun=1, pointers unchanged.
  - Full, push and pop in the same cycle: both occur, count stays 4, no overrun.
  - Empty, push and pop in the same cycle: the pop is invalid because m_valid=0; the push occurs.
  - flush: count→0, pointers→0, m_valid→0. flush beats a same-cycle push or pop. overrun is unaffected.
  - ovr_clr together with a new overrun event: set wins.
- Arithmetic:
  - fifo_count = count register, 3 bits, never exceeds 4.
  - Timeout counter width = clog2(TIMEOUT_BITS*OSR+1); it saturates at its terminal value.

## Timing
- Reset values: state OFF, bgen_enable 0, bgen_final_value RESET_DIV, cfg_pending 0, busy 0, m_valid 0, m_data 0, fifo_count 0, overrun 0, timeout_irq 0. Pending register = RESET_DIV.
- rx_done_tick at edge N: the byte is written at N. m_valid and m_data are valid after N, i.e. one cycle of latency.
- Pop at edge P: the next entry appears on m_data after P, or m_valid drops after P if the FIFO is now empty.
- State transitions take effect on the edge where their condition is true. busy and bgen_enable are registered outputs that follow the state.
- cfg_wr at edge W while in IDLE: cfg_pending=1 after W. bgen_final_value updates and cfg_pending clears at W+1.

## Configuration
- UART_RX_CTRL_TIMEOUT_EN defined:
  - The timeout counter counts s_tick while state=IDLE and fifo_count>0.
  - It clears on any push, pop, or flush.
  - When it reaches TIMEOUT_BITS*OSR, timeout_irq=1.
  - timeout_irq stays high until the next pop, flush, or push.
- Not defined: no counter is synthesised and timeout_irq is tied to 0.

## Test plan
- Reset: hold reset_n=0 for 2 cycles → bgen_final_value=196, bgen_enable=0, m_valid=0, fifo_count=0, all flags 0.
- Enable and single frame: cfg_en=1, drive 0xA5 as an 8N1 frame at 16 s_tick/bit → busy rises on the start edge and falls on rx_done_tick. m_data=0xA5 and m_valid=1 one cycle after the tick. Pop with m_ready=1 → fifo_count=0.
- Overrun: push 0x11,0x22,0x33,0x44,0x55 with m_ready=0 → fifo_count=4, overrun=1. Pops return 0x11..0x44 in order. ovr_clr → overrun=0.
- Full-boundary simultaneous events: FIFO full and m_ready=1 on the same edge as rx_done_tick (0x66) → count stays 4, overrun=0, 0x66 is the last entry popped. flush together with a push → count=0.
- Divisor deferral: cfg_wr with cfg_div=98 while busy=1 → cfg_pending=1 and bgen_final_value stays 196 until the frame's rx_done_tick; it becomes 98 the following cycle. Drop cfg_en mid-frame → state OFF and the late rx_done_tick does not push.
- Timeout (macro on): one byte left in the FIFO, idle line → timeout_irq=1 after 64 s_ticks; the pop clears it. With the macro off, timeout_irq stays 0.
